tdm_slot_scheduler: RTL and testbench

- Shares one output channel among 4 requesters, each with a valid/ready handshake.
- Two selectable policies:
  - work-conserving round-robin (mode 0);
  - strict time-division slots (mode 1), matching the fixed 4-way TDM sequencing used by the mod-3/4 mux datapath.
- Output is a one-entry registered stage tagged with the source index.
- Sits between the data producers and the TDM channel consumer; runtime configuration loads through a single write strobe.

---
 rtl/tdm_pkg.sv | 14 +
 rtl/rr_pick4.sv | 28 ++
 rtl/tdm_slot_scheduler.sv | 106 ++++++++++
 tb/tb_tdm_slot_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants for the TDM slot scheduler: requester count, index width,
// mode encodings and reset values of the configuration and pointer registers.
package tdm_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_TDM = 1'b1;

    localparam logic [NREQ-1:0]  SLOT_EN_RST = 4'b1111;
    localparam logic [IDX_W-1:0] RR_PTR_RST  = 2'd3;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set bit of cand searching from
// ptr+1 upward, wrapping modulo 4.
module rr_pick4
    import tdm_pkg::*;
(
    input  logic [NREQ-1:0]  cand,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        // k = NREQ wraps back to ptr itself, so the last winner is checked last
        for (int k = 1; k <= int'(NREQ); k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/tdm_slot_scheduler.sv
// Four-requester channel scheduler with round-robin or strict TDM policy,
// feeding a one-entry registered output stage tagged with the source index.
module tdm_slot_scheduler #(
    parameter int unsigned DW   = 2,
    parameter int unsigned NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              cfg_we,
    input  logic [NREQ-1:0]   cfg_slot_en,
    input  logic              cfg_mode,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [1:0]        out_sel,
    input  logic              out_ready,
    output logic [1:0]        cur_slot
);

    import tdm_pkg::*;

    logic [NREQ-1:0]  slot_en_q;
    logic             mode_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] cur_slot_q;
    logic             out_valid_q;
    logic [DW-1:0]    out_data_q;
    logic [IDX_W-1:0] out_sel_q;

    logic             load;
    logic [NREQ-1:0]  cand;
    logic [IDX_W-1:0] rr_win;
    logic             rr_found;
    logic [IDX_W-1:0] grant_idx;
    logic             grant;

    assign load = !out_valid_q || out_ready;
    assign cand = req_valid & slot_en_q;

    rr_pick4 u_pick (
        .cand   (cand),
        .ptr    (rr_ptr_q),
        .winner (rr_win),
        .found  (rr_found)
    );

    always_comb begin
        grant_idx = rr_win;
        grant     = rr_found;
        if (mode_q == MODE_TDM) begin
            grant_idx = cur_slot_q;
            grant     = cand[cur_slot_q];
        end
        grant     = grant && load && rst;
        req_ready = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_en_q   <= SLOT_EN_RST;
            mode_q      <= MODE_RR;
            rr_ptr_q    <= RR_PTR_RST;
            cur_slot_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            if (grant) begin
                out_valid_q <= 1'b1;
                out_data_q  <= req_data[grant_idx*DW +: DW];
                out_sel_q   <= grant_idx;
                if (mode_q == MODE_RR) begin
                    rr_ptr_q <= grant_idx;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            // Slot counter free-runs in TDM mode so an idle slot is simply lost
            if (mode_q == MODE_TDM) begin
                cur_slot_q <= cur_slot_q + 1'b1;
            end

            // Later assignments override the arbitration updates above on a mode switch
            if (cfg_we) begin
                slot_en_q <= cfg_slot_en;
                mode_q    <= cfg_mode;
                if (cfg_mode != mode_q) begin
                    cur_slot_q <= '0;
                    rr_ptr_q   <= RR_PTR_RST;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign cur_slot  = cur_slot_q;

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Directed bench for tdm_slot_scheduler: a driver pushes expected beats into a
// queue, a monitor pops them whenever the output handshake completes.
module tb_tdm_slot_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req_valid;
    logic [7:0] req_data;
    logic [3:0] req_ready;
    logic       cfg_we;
    logic [3:0] cfg_slot_en;
    logic       cfg_mode;
    logic       out_valid;
    logic [1:0] out_data;
    logic [1:0] out_sel;
    logic       out_ready;
    logic [1:0] cur_slot;

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] exp_q[$];  // {sel, data}

    tdm_slot_scheduler #(
        .DW   (2),
        .NREQ (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .cfg_we      (cfg_we),
        .cfg_slot_en (cfg_slot_en),
        .cfg_mode    (cfg_mode),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sel     (out_sel),
        .out_ready   (out_ready),
        .cur_slot    (cur_slot)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic step(input logic r, input logic [3:0] v, input logic rdy,
                        input logic we, input logic [3:0] se, input logic md);
        @(posedge clk);
        #1;
        rst         = r;
        req_valid   = v;
        out_ready   = rdy;
        cfg_we      = we;
        cfg_slot_en = se;
        cfg_mode    = md;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {4'd0, out_sel, out_data}, 8'hff);
            end else begin
                chk("beat", {4'd0, out_sel, out_data}, {4'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [1:0] s;
        logic       g;
        logic       prev_g;
        logic [3:0] rr;

        rst = 1'b0; req_valid = 4'b1111; out_ready = 1'b0;
        cfg_we = 1'b0; cfg_slot_en = 4'b0000; cfg_mode = 1'b0;
        req_data = {2'd3, 2'd2, 2'd1, 2'd0};

        // Reset state
        step(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_out_data", {6'd0, out_data}, 8'd0);
        chk("rst_out_sel", {6'd0, out_sel}, 8'd0);
        chk("rst_cur_slot", {6'd0, cur_slot}, 8'd0);
        chk("rst_req_ready", {4'd0, req_ready}, 8'd0);

        // Round-robin fairness: 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0);
            rr = 4'b0001 << (k % 4);
            chk("rr_ready", {4'd0, req_ready}, {4'd0, rr});
            chk("rr_out_valid", {7'd0, out_valid}, {7'd0, (k > 0)});
            exp_q.push_back({2'(k % 4), 2'(k % 4)});
        end
        step(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk("rr_last_valid", {7'd0, out_valid}, 8'd1);

        // Backpressure with only requester 2 valid
        step(1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk("bp_first_ready", {4'd0, req_ready}, 8'b0100);
        exp_q.push_back({2'd2, 2'd2});
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0);
            chk("bp_hold_ready", {4'd0, req_ready}, 8'd0);
            chk("bp_hold_valid", {7'd0, out_valid}, 8'd1);
            chk("bp_hold_data", {4'd0, out_sel, out_data}, 8'b1010);
        end
        step(1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk("bp_release_ready", {4'd0, req_ready}, 8'b0100);
        exp_q.push_back({2'd2, 2'd2});
        step(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk("bp_stay_valid", {7'd0, out_valid}, 8'd1);

        // Switch to strict TDM, only requester 1 valid
        step(1'b1, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b1);
        chk("tdm_cfg_valid", {7'd0, out_valid}, 8'd0);
        prev_g = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0);
            s = 2'(k % 4);
            g = (s == 2'd1);
            chk("tdm_slot", {6'd0, cur_slot}, {6'd0, s});
            chk("tdm_ready", {4'd0, req_ready}, g ? 8'b0010 : 8'd0);
            chk("tdm_valid", {7'd0, out_valid}, {7'd0, prev_g});
            if (g) exp_q.push_back({2'd1, 2'd1});
            prev_g = g;
        end

        // Mask 1010, all valid: only slots 1 and 3 load
        step(1'b1, 4'b0000, 1'b1, 1'b1, 4'b1010, 1'b1);
        chk("mask_cfg_slot", {6'd0, cur_slot}, 8'd0);
        chk("mask_cfg_valid", {7'd0, out_valid}, {7'd0, prev_g});
        prev_g = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0);
            s = 2'((k + 1) % 4);
            g = s[0];
            rr = 4'b0001 << s;
            chk("mask_slot", {6'd0, cur_slot}, {6'd0, s});
            chk("mask_ready", {4'd0, req_ready}, g ? {4'd0, rr} : 8'd0);
            chk("mask_valid", {7'd0, out_valid}, {7'd0, prev_g});
            if (g) exp_q.push_back({s, s});
            prev_g = g;
        end

        // Back to round-robin, then disable every slot
        step(1'b1, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0);
        chk("rr2_cfg_valid", {7'd0, out_valid}, {7'd0, prev_g});
        step(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0);
        chk("rr2_slot_reset", {6'd0, cur_slot}, 8'd0);
        chk("rr2_ready_old_cfg", {4'd0, req_ready}, 8'b0001);
        exp_q.push_back({2'd0, 2'd0});
        step(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("off_ready_bp", {4'd0, req_ready}, 8'd0);
        chk("off_valid_bp", {7'd0, out_valid}, 8'd1);
        step(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk("off_ready_drain", {4'd0, req_ready}, 8'd0);
        step(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk("off_drained", {7'd0, out_valid}, 8'd0);
        chk("off_ready_idle", {4'd0, req_ready}, 8'd0);

        // Mid-stream reset while TDM beat is held
        step(1'b1, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b1);
        step(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("mr_slot0", {6'd0, cur_slot}, 8'd0);
        chk("mr_ready_pre", {4'd0, req_ready}, 8'b0001);
        step(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("mr_ready_in_rst", {4'd0, req_ready}, 8'd0);
        chk("mr_valid_in_rst", {7'd0, out_valid}, 8'd1);
        exp_q.delete();
        step(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk("mr_valid_after", {7'd0, out_valid}, 8'd0);
        chk("mr_slot_after", {6'd0, cur_slot}, 8'd0);
        chk("mr_first_grant", {4'd0, req_ready}, 8'b0001);
        exp_q.push_back({2'd0, 2'd0});
        step(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk("mr_mode_rr_hold", {6'd0, cur_slot}, 8'd0);
        chk("mr_beat_valid", {7'd0, out_valid}, 8'd1);
        step(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk("mr_drained", {7'd0, out_valid}, 8'd0);

        chk("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
